// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operation request and result handshake bundle for alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [5:0]         op;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH/2-1:0] imm;
  logic               highlow;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               flag;
  logic               illegal;

  modport master (
    output in_valid, op, a, b, imm, highlow, out_ready,
    input  in_ready, out_valid, result, flag, illegal
  );

  modport slave (
    input  in_valid, op, a, b, imm, highlow, out_ready,
    output in_ready, out_valid, result, flag, illegal
  );
endinterface

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU: single-cycle arithmetic/compare, bit-serial shifts and shift-add multiply
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic       clock,
  input logic       reset,
  alu_seq_if.slave  bus
);
  localparam int H = WIDTH / 2;

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_SUB  = 6'd1;
  localparam logic [5:0] OP_SHL1 = 6'd2;
  localparam logic [5:0] OP_SHR1 = 6'd3;
  localparam logic [5:0] OP_PS4  = 6'd4;
  localparam logic [5:0] OP_LDH  = 6'd5;
  localparam logic [5:0] OP_PS6  = 6'd6;
  localparam logic [5:0] OP_PS7  = 6'd7;
  localparam logic [5:0] OP_EQ   = 6'd8;
  localparam logic [5:0] OP_LTU  = 6'd9;
  localparam logic [5:0] OP_GTU  = 6'd10;
  localparam logic [5:0] OP_SHL0 = 6'd16;
  localparam logic [5:0] OP_SRA  = 6'd17;
  localparam logic [5:0] OP_MUL  = 6'd18;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [5:0]       op_r;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [SHW-1:0]   cnt;
  logic             flag_r;
  logic             ill_r;
  logic             accept;
  logic             is_shift;
  logic             is_mul;
  logic [SHW-1:0]   k;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    accept        = bus.in_valid && (state == IDLE);
    is_shift      = (bus.op == OP_SHL1) || (bus.op == OP_SHR1) ||
                    (bus.op == OP_SHL0) || (bus.op == OP_SRA);
    is_mul        = (bus.op == OP_MUL);
    // shift amounts at or beyond the width all produce the same all-fill result
    k             = (bus.b >= WIDTH'(WIDTH)) ? SHW'(WIDTH) : bus.b[SHW-1:0];
    state_nx      = state;
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    case (state)
      IDLE:    if (accept) state_nx = (is_mul || (is_shift && k != '0)) ? RUN : DONE;
      RUN:     if (cnt == SHW'(1)) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      op_r   <= '0;
      res    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      flag_r <= 1'b0;
      ill_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          op_r   <= bus.op;
          mcand  <= bus.a;
          mplier <= bus.b;
          cnt    <= k;
          flag_r <= 1'b0;
          ill_r  <= 1'b0;
          res    <= '0;
          case (bus.op)
            OP_ADD:                  res    <= bus.a + bus.b;
            OP_SUB:                  res    <= bus.a - bus.b;
            OP_PS4, OP_PS6, OP_PS7:  res    <= bus.a;
            OP_LDH:                  res    <= bus.highlow ? {bus.imm, bus.a[H-1:0]}
                                                           : {bus.a[WIDTH-1:H], bus.imm};
            OP_EQ:                   flag_r <= (bus.a == bus.b);
            OP_LTU:                  flag_r <= (bus.a < bus.b);
            OP_GTU:                  flag_r <= (bus.a > bus.b);
            OP_SHL1, OP_SHR1,
            OP_SHL0, OP_SRA:         res    <= bus.a;
            OP_MUL:                  cnt    <= SHW'(WIDTH);
            default:                 ill_r  <= 1'b1;
          endcase
        end
        RUN: begin
          cnt <= cnt - SHW'(1);
          case (op_r)
            OP_SHL1: res <= {res[WIDTH-2:0], 1'b1};
            OP_SHR1: res <= {1'b1, res[WIDTH-1:1]};
            OP_SHL0: res <= {res[WIDTH-2:0], 1'b0};
            OP_SRA:  res <= {res[WIDTH-1], res[WIDTH-1:1]};
            OP_MUL: begin
              if (mplier[0]) res <= res + mcand;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
            end
            default: res <= res;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.result  = res;
  assign bus.flag    = flag_r;
  assign bus.illegal = ill_r;
endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - randomized and directed checks of alu_seq against an arithmetic reference model
module tb_alu_seq;
  localparam int W = 32;

  typedef struct {
    logic [W-1:0] res;
    logic         flg;
    logic         ill;
    int           lat;
    int           acc;
    int           hold;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   npass = 0;
  int   ntot  = 0;
  exp_t q[$];
  int   wait_c = 0;
  bit   first  = 1'b1;

  alu_seq_if #(.WIDTH(W)) bus ();
  alu_seq #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    ntot++;
    if (got === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, got, exp, cyc);
  endtask

  function automatic exp_t model(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W/2-1:0] imm, input logic hl);
    exp_t        e;
    int          k;
    logic [63:0] p;
    e.res = '0; e.flg = 1'b0; e.ill = 1'b0; e.lat = 1; e.acc = 0; e.hold = 0;
    k = (b >= 32'd32) ? 32 : int'(b);
    case (op)
      6'd0:             e.res = a + b;
      6'd1:             e.res = a - b;
      6'd4, 6'd6, 6'd7: e.res = a;
      6'd5:             e.res = hl ? {imm, a[15:0]} : {a[31:16], imm};
      6'd8:             e.flg = (a == b);
      6'd9:             e.flg = (a < b);
      6'd10:            e.flg = (a > b);
      6'd2:  begin e.res = (k == 32) ? '1 : ((a << k) | ((32'h1 << k) - 32'h1)); e.lat = k + 1; end
      6'd3:  begin e.res = (k == 32) ? '1 : ((a >> k) | ~(32'hFFFF_FFFF >> k)); e.lat = k + 1; end
      6'd16: begin e.res = (k == 32) ? '0 : (a << k); e.lat = k + 1; end
      6'd17: begin e.res = (k == 32) ? {32{a[31]}} : 32'($signed(a) >>> k); e.lat = k + 1; end
      6'd18: begin p = 64'(a) * 64'(b); e.res = p[31:0]; e.lat = 33; end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // single compare process: owns out_ready and checks every valid output cycle
  always @(negedge clock) begin
    if (reset) begin
      bus.out_ready = 1'b0;
      first = 1'b1;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_out_valid", 1, 0);
        bus.out_ready = 1'b1;
      end else begin
        if (first) begin
          chk("latency", 64'(cyc - q[0].acc), 64'(q[0].lat));
          wait_c = q[0].hold;
          first = 1'b0;
        end
        chk("result", bus.result, q[0].res);
        chk("flag", bus.flag, q[0].flg);
        chk("illegal", bus.illegal, q[0].ill);
        chk("in_ready_in_done", bus.in_ready, 0);
        if (wait_c == 0) begin
          bus.out_ready = 1'b1;
          void'(q.pop_front());
          first = 1'b1;
        end else begin
          bus.out_ready = 1'b0;
          wait_c--;
        end
      end
    end else begin
      bus.out_ready = 1'b0;
    end
  end

  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [15:0] imm, input logic hl, input int hold);
    int   t;
    exp_t e;
    t = 0;
    while (!bus.in_ready && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) begin
      chk("in_ready_timeout", 0, 1);
      return;
    end
    e = model(op, a, b, imm, hl);
    e.acc = cyc;
    e.hold = hold;
    q.push_back(e);
    bus.op = op; bus.a = a; bus.b = b; bus.imm = imm; bus.highlow = hl;
    bus.in_valid = 1'b1;
    @(negedge clock);
    bus.in_valid = 1'b0;
    bus.op = 6'($urandom); bus.a = $urandom; bus.b = $urandom;
    bus.imm = 16'($urandom); bus.highlow = 1'($urandom);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0 || bus.out_valid) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (t >= 2000) chk("drain_timeout", 0, 1);
  endtask

  logic [5:0] optab [14] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd4, 6'd5, 6'd6, 6'd7,
                             6'd8, 6'd9, 6'd10, 6'd16, 6'd17, 6'd18};

  initial begin
    exp_t       e;
    logic [5:0] op;
    logic [31:0] a, b;
    bus.in_valid = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.imm = '0; bus.highlow = 1'b0;
    bus.out_ready = 1'b0;

    e = model(6'd0, 32'hFFFF_FFFF, 32'd2, 16'h0, 1'b0);  chk("pin_add", e.res, 32'h1);
    e = model(6'd1, 32'd3, 32'd5, 16'h0, 1'b0);          chk("pin_sub", e.res, 32'hFFFF_FFFE);
    e = model(6'd2, 32'hF, 32'd4, 16'h0, 1'b0);          chk("pin_shl1", e.res, 32'hFF);
    chk("pin_shl1_lat", 64'(e.lat), 5);
    e = model(6'd17, 32'h8000_0000, 32'd31, 16'h0, 1'b0); chk("pin_sra", e.res, 32'hFFFF_FFFF);
    e = model(6'd18, 32'h0001_0001, 32'd3, 16'h0, 1'b0); chk("pin_mul", e.res, 32'h0003_0003);
    e = model(6'd5, 32'h1234_5678, 32'd0, 16'hBEEF, 1'b1); chk("pin_ldh_hi", e.res, 32'hBEEF_5678);
    e = model(6'd5, 32'h1234_5678, 32'd0, 16'hBEEF, 1'b0); chk("pin_ldh_lo", e.res, 32'h1234_BEEF);

    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_flag", bus.flag, 0);
    chk("rst_illegal", bus.illegal, 0);

    issue(6'd0,  32'hFFFF_FFFF, 32'd2, 16'h0, 1'b0, 0);
    issue(6'd1,  32'd3, 32'd5, 16'h0, 1'b0, 1);
    issue(6'd2,  32'hF, 32'd4, 16'h0, 1'b0, 0);
    issue(6'd17, 32'h8000_0000, 32'd31, 16'h0, 1'b0, 0);
    issue(6'd16, 32'hDEAD_BEEF, 32'd40, 16'h0, 1'b0, 0);
    issue(6'd3,  32'h1357_9BDF, 32'd0, 16'h0, 1'b0, 0);
    issue(6'd18, 32'h0001_0001, 32'd3, 16'h0, 1'b0, 0);
    issue(6'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 1'b0, 2);
    issue(6'd9,  32'd1, 32'hFFFF_FFFF, 16'h0, 1'b0, 0);
    issue(6'd8,  32'd7, 32'd7, 16'h0, 1'b0, 0);
    issue(6'd5,  32'h1234_5678, 32'd0, 16'hBEEF, 1'b1, 0);
    issue(6'd5,  32'h1234_5678, 32'd0, 16'hBEEF, 1'b0, 0);
    issue(6'h3F, 32'h55, 32'hAA, 16'h0, 1'b0, 0);
    drain();

    // backpressure: keep offering a new op while the finished ADD is held
    issue(6'd0, 32'd100, 32'd23, 16'h0, 1'b0, 10);
    bus.op = 6'd0; bus.a = 32'd5; bus.b = 32'd5; bus.in_valid = 1'b1;
    repeat (5) @(negedge clock);
    bus.in_valid = 1'b0;
    drain();
    chk("bp_idle_in_ready", bus.in_ready, 1);

    // reset in the middle of a multiply
    issue(6'd18, 32'h1234_5678, 32'h9ABC_DEF0, 16'h0, 1'b0, 0);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    q.delete();
    @(negedge clock);
    chk("midrst_out_valid", bus.out_valid, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_result", bus.result, 0);
    issue(6'd0, 32'd2, 32'd2, 16'h0, 1'b0, 0);
    drain();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 14) == 0) begin
        op = 6'($urandom_range(19, 63));
        if (op == 6'd16 || op == 6'd17 || op == 6'd18) op = 6'd63;
      end else begin
        op = optab[$urandom_range(0, 13)];
      end
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
      if (op >= 6'd8 && op <= 6'd10 && $urandom_range(0, 2) == 0) b = a;
      issue(op, a, b, 16'($urandom), 1'($urandom), $urandom_range(0, 3));
    end
    drain();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
